// File: rtl/vanilla_idiv_seq_pkg.sv
// Shared types for the vanilla core integer divide/remainder unit.
package vanilla_idiv_seq_pkg;

  localparam int reg_data_width_gp      = 32;
  localparam int RV32_reg_addr_width_gp = 5;

  // Operation select, already decoded from RV32M funct3 upstream.
  typedef enum logic [1:0] {
    IDIV_DIV  = 2'd0,
    IDIV_DIVU = 2'd1,
    IDIV_REM  = 2'd2,
    IDIV_REMU = 2'd3
  } idiv_op_e;

  // Request bundle as presented by the execute stage.
  typedef struct packed {
    idiv_op_e                          op;
    logic [reg_data_width_gp-1:0]      rs1;
    logic [reg_data_width_gp-1:0]      rs2;
    logic [RV32_reg_addr_width_gp-1:0] rd;
  } idiv_req_s;

  function automatic logic idiv_is_signed(idiv_op_e op);
    return (op == IDIV_DIV) || (op == IDIV_REM);
  endfunction

  function automatic logic idiv_is_rem(idiv_op_e op);
    return (op == IDIV_REM) || (op == IDIV_REMU);
  endfunction

endpackage

// File: rtl/vanilla_idiv_seq_if.sv
// Request/result bundle between the execute stage and the divide unit.
//
// Handshake: a request transfers on a rising clock edge where v_i and ready_o
// are both high; kill_i squashes any in-flight op (and drops a same-cycle
// request). A result is offered while v_o is high and retires on the edge
// where yumi_i is high; result_o/rd_o are stable until then, and yumi_i may
// only be raised while v_o is high.
interface vanilla_idiv_seq_if
  import vanilla_idiv_seq_pkg::*;
#(
  parameter int width_p     = reg_data_width_gp,
  parameter int tag_width_p = RV32_reg_addr_width_gp
) ();

  logic                   v_i;
  logic                   ready_o;
  idiv_op_e               op_i;
  logic [width_p-1:0]     rs1_i;
  logic [width_p-1:0]     rs2_i;
  logic [tag_width_p-1:0] rd_i;
  logic                   kill_i;
  logic                   v_o;
  logic [width_p-1:0]     result_o;
  logic [tag_width_p-1:0] rd_o;
  logic                   yumi_i;

  modport slave (
    input  v_i, op_i, rs1_i, rs2_i, rd_i, kill_i, yumi_i,
    output ready_o, v_o, result_o, rd_o
  );

  modport master (
    output v_i, op_i, rs1_i, rs2_i, rd_i, kill_i, yumi_i,
    input  ready_o, v_o, result_o, rd_o
  );

endinterface

// File: rtl/vanilla_idiv_seq_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module vanilla_idiv_seq_step #(
  parameter int width_p = 32
) (
  input  logic [width_p:0]   rem_i,
  input  logic               msb_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p:0]   rem_o,
  output logic               q_o
);

  logic [width_p+1:0] shifted;
  logic [width_p+1:0] diff;

  // The borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    shifted = {rem_i, msb_i};
    diff    = shifted - {2'b00, divisor_i};
    q_o     = ~diff[width_p+1];
    rem_o   = q_o ? diff[width_p:0] : shifted[width_p:0];
  end

endmodule

// File: rtl/vanilla_idiv_seq.sv
// Iterative RV32M divide/remainder unit: one quotient bit per cycle, with
// single-cycle fast paths for divide-by-zero and signed overflow.
module vanilla_idiv_seq
  import vanilla_idiv_seq_pkg::*;
#(
  parameter int width_p     = reg_data_width_gp,
  parameter int tag_width_p = RV32_reg_addr_width_gp
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  vanilla_idiv_seq_if.slave   bus,
  output logic [1:0]          state_o
);

  localparam int cnt_w_lp = $clog2(width_p) + 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);
  localparam logic [width_p-1:0]  min_int_lp  = {1'b1, {(width_p-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_r, state_n;
  logic [cnt_w_lp-1:0]    cnt_r;
  logic [width_p-1:0]     dvd_r;
  logic [width_p-1:0]     dvs_r;
  logic [width_p:0]       rem_r;
  logic [width_p-1:0]     result_r;
  logic [tag_width_p-1:0] rd_r;
  logic                   is_rem_r;
  logic                   neg_q_r;
  logic                   neg_r_r;

  logic                   accept;
  logic                   last_step;
  logic                   is_signed;
  logic                   is_rem;
  logic                   rs1_neg;
  logic                   rs2_neg;
  logic [width_p-1:0]     rs1_mag;
  logic [width_p-1:0]     rs2_mag;
  logic                   div_zero;
  logic                   overflow;
  logic [width_p-1:0]     fast_result;

  logic [width_p:0]       rem_next;
  logic                   q_bit;
  logic [width_p-1:0]     quot_final;
  logic [width_p-1:0]     rem_final;
  logic [width_p-1:0]     calc_result;

  vanilla_idiv_seq_step #(.width_p(width_p)) u_step (
    .rem_i     (rem_r),
    .msb_i     (dvd_r[width_p-1]),
    .divisor_i (dvs_r),
    .rem_o     (rem_next),
    .q_o       (q_bit)
  );

  // Decode the incoming request: magnitudes, fast-path detection and result.
  always_comb begin
    is_signed   = idiv_is_signed(bus.op_i);
    is_rem      = idiv_is_rem(bus.op_i);
    rs1_neg     = is_signed & bus.rs1_i[width_p-1];
    rs2_neg     = is_signed & bus.rs2_i[width_p-1];
    rs1_mag     = rs1_neg ? -bus.rs1_i : bus.rs1_i;
    rs2_mag     = rs2_neg ? -bus.rs2_i : bus.rs2_i;
    div_zero    = (bus.rs2_i == '0);
    overflow    = is_signed & (bus.rs1_i == min_int_lp) & (bus.rs2_i == '1);
    fast_result = '0;
    if (div_zero) begin
      fast_result = is_rem ? bus.rs1_i : '1;
    end else begin
      fast_result = is_rem ? '0 : min_int_lp;
    end
  end

  // Final step result with sign fixup and quotient/remainder select.
  always_comb begin
    quot_final  = {dvd_r[width_p-2:0], q_bit};
    rem_final   = rem_next[width_p-1:0];
    calc_result = is_rem_r ? (neg_r_r ? -rem_final  : rem_final)
                           : (neg_q_r ? -quot_final : quot_final);
  end

  // Next-state logic; kill wins over both a new request and yumi.
  always_comb begin
    state_n   = state_r;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.v_i && !bus.kill_i) begin
          accept  = 1'b1;
          state_n = (div_zero || overflow) ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.kill_i) begin
          state_n = IDLE;
        end else if (cnt_r == last_cnt_lp) begin
          last_step = 1'b1;
          state_n   = DONE;
        end
      end
      DONE: begin
        if (bus.kill_i || bus.yumi_i) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath: latch the request, iterate, and register the final result.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r    <= '0;
      dvd_r    <= '0;
      dvs_r    <= '0;
      rem_r    <= '0;
      result_r <= '0;
      rd_r     <= '0;
      is_rem_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (accept) begin
      cnt_r    <= '0;
      dvd_r    <= rs1_mag;
      dvs_r    <= rs2_mag;
      rem_r    <= '0;
      rd_r     <= bus.rd_i;
      is_rem_r <= is_rem;
      neg_q_r  <= is_signed & (bus.rs1_i[width_p-1] ^ bus.rs2_i[width_p-1]);
      neg_r_r  <= rs1_neg;
      if (div_zero || overflow) begin
        result_r <= fast_result;
      end
    end else if (state_r == CALC && !bus.kill_i) begin
      dvd_r <= {dvd_r[width_p-2:0], q_bit};
      rem_r <= rem_next;
      cnt_r <= cnt_r + cnt_w_lp'(1);
      if (last_step) begin
        result_r <= calc_result;
      end
    end
  end

  assign bus.ready_o  = (state_r == IDLE);
  assign bus.v_o      = (state_r == DONE);
  assign bus.result_o = result_r;
  assign bus.rd_o     = rd_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_vanilla_idiv_seq.sv
// Directed bench for vanilla_idiv_seq: vector table plus handshake, kill and
// reset sequences.
module tb_vanilla_idiv_seq;
  import vanilla_idiv_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clk = ~clk;

  vanilla_idiv_seq_if #(.width_p(32), .tag_width_p(5)) bus ();

  vanilla_idiv_seq dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus),
    .state_o   (state_dbg)
  );

  typedef struct {
    idiv_op_e    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic start_op(input idiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bus.op_i  = op;
    bus.rs1_i = a;
    bus.rs2_i = b;
    bus.rd_i  = rd;
    bus.v_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.v_i   = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.v_o !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result();
    bus.yumi_i = 1'b1;
    @(posedge clk);
    #1;
    bus.yumi_i = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    start_op(v.op, v.a, v.b, v.rd);
    wait_result(lat);
    check({name, "_lat"}, 32'(lat), 32'(v.lat));
    check({name, "_res"}, bus.result_o, v.exp);
    check({name, "_rd"}, 32'(bus.rd_o), 32'(v.rd));
    take_result();
    check({name, "_ready_after_yumi"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    int lat;
    int seen_v;
    vec_t v;

    bus.v_i = 1'b0; bus.op_i = IDIV_DIV; bus.rs1_i = '0; bus.rs2_i = '0;
    bus.rd_i = '0; bus.kill_i = 1'b0; bus.yumi_i = 1'b0;

    vecs.push_back('{IDIV_DIVU, 32'd100,        32'd7,          5'd1,  32'd14,         33});
    vecs.push_back('{IDIV_REMU, 32'd100,        32'd7,          5'd2,  32'd2,          33});
    vecs.push_back('{IDIV_DIV,  32'hFFFFFFF9,   32'd2,          5'd3,  32'hFFFFFFFD,   33});
    vecs.push_back('{IDIV_REM,  32'hFFFFFFF9,   32'd2,          5'd4,  32'hFFFFFFFF,   33});
    vecs.push_back('{IDIV_DIV,  32'd7,          32'hFFFFFFFE,   5'd5,  32'hFFFFFFFD,   33});
    vecs.push_back('{IDIV_REM,  32'd7,          32'hFFFFFFFE,   5'd6,  32'd1,          33});
    vecs.push_back('{IDIV_DIVU, 32'd5,          32'd0,          5'd7,  32'hFFFFFFFF,   1});
    vecs.push_back('{IDIV_REM,  32'hFFFFFFF9,   32'd0,          5'd8,  32'hFFFFFFF9,   1});
    vecs.push_back('{IDIV_DIV,  32'h80000000,   32'hFFFFFFFF,   5'd9,  32'h80000000,   1});
    vecs.push_back('{IDIV_REM,  32'h80000000,   32'hFFFFFFFF,   5'd10, 32'd0,          1});
    vecs.push_back('{IDIV_DIVU, 32'h80000000,   32'hFFFFFFFF,   5'd11, 32'd0,          33});
    vecs.push_back('{IDIV_REMU, 32'h80000000,   32'hFFFFFFFF,   5'd12, 32'h80000000,   33});
    vecs.push_back('{IDIV_DIVU, 32'hFFFFFFFF,   32'd1,          5'd13, 32'hFFFFFFFF,   33});
    vecs.push_back('{IDIV_REMU, 32'hFFFFFFFF,   32'd10,         5'd14, 32'd5,          33});
    vecs.push_back('{IDIV_DIVU, 32'd3,          32'd5,          5'd15, 32'd0,          33});
    vecs.push_back('{IDIV_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd16, 32'd14,         33});
    vecs.push_back('{IDIV_REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   5'd17, 32'hFFFFFFFE,   33});
    vecs.push_back('{IDIV_DIV,  32'h80000000,   32'd2,          5'd18, 32'hC0000000,   33});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_v_o", 32'(bus.v_o), 32'd0);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_rd", 32'(bus.rd_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: hold yumi low for 10 cycles
    start_op(IDIV_DIVU, 32'd100, 32'd7, 5'd9);
    wait_result(lat);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_res_%0d", i), bus.result_o, 32'd14);
      check($sformatf("bp_rd_%0d", i), 32'(bus.rd_o), 32'd9);
      check($sformatf("bp_ready_%0d", i), 32'(bus.ready_o), 32'd0);
      check($sformatf("bp_v_%0d", i), 32'(bus.v_o), 32'd1);
    end
    take_result();
    check("bp_ready_u1", 32'(bus.ready_o), 32'd1);
    v = '{IDIV_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33};
    run_vec("b2b", v);

    // Kill during CALC
    start_op(IDIV_DIV, 32'hFFFFFF9C, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    check("kill_calc_ready", 32'(bus.ready_o), 32'd1);
    check("kill_calc_state", 32'(state_dbg), 32'd0);
    seen_v = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.v_o === 1'b1) seen_v = 1;
      @(posedge clk);
      #1;
    end
    check("kill_calc_no_v", 32'(seen_v), 32'd0);

    // Kill together with a request in IDLE drops the request
    bus.op_i = IDIV_DIVU; bus.rs1_i = 32'd5; bus.rs2_i = 32'd0; bus.rd_i = 5'd21;
    bus.v_i = 1'b1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.v_i = 1'b0;
    bus.kill_i = 1'b0;
    check("kill_idle_state", 32'(state_dbg), 32'd0);
    check("kill_idle_v", 32'(bus.v_o), 32'd0);
    @(posedge clk);
    #1;
    check("kill_idle_v2", 32'(bus.v_o), 32'd0);

    // Kill overrides yumi in DONE
    start_op(IDIV_DIVU, 32'd5, 32'd0, 5'd22);
    wait_result(lat);
    check("kdone_lat", 32'(lat), 32'd1);
    bus.kill_i = 1'b1;
    bus.yumi_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    bus.yumi_i = 1'b0;
    check("kdone_v", 32'(bus.v_o), 32'd0);
    check("kdone_ready", 32'(bus.ready_o), 32'd1);

    // Asynchronous reset in the middle of CALC
    start_op(IDIV_DIVU, 32'd1000, 32'd3, 5'd12);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(bus.ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_v", 32'(bus.v_o), 32'd0);
    check("arst_result", bus.result_o, 32'd0);
    check("arst_rd", 32'(bus.rd_o), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{IDIV_DIVU, 32'd9, 32'd3, 5'd1, 32'd3, 33};
    run_vec("post_rst", v);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vanilla_idiv_seq.md
# vanilla_idiv_seq

Iterative 32-bit integer divide/remainder unit for the vanilla core execute stage. It sits beside the single-cycle ALU and accepts the same decoded operands (rs1/rs2 values after forwarding) for RV32M DIV/DIVU/REM/REMU. It produces one quotient bit per cycle and hands the result and destination register tag to the writeback arbiter through a valid/yumi handshake. Pipeline control must stall issue while `ready_o` is low.

## Interface
- `width_p`, default `reg_data_width_gp` (32): operand and result width.
- `tag_width_p`, default `RV32_reg_addr_width_gp` (5): destination register tag width.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `v_i` in 1: request valid.
- `ready_o` out 1: unit can accept; high only in IDLE.
- `op_i` in `idiv_op_e` (2): DIV=0, DIVU=1, REM=2, REMU=3.
- `rs1_i` in `width_p`: dividend.
- `rs2_i` in `width_p`: divisor.
- `rd_i` in `tag_width_p`: destination tag.
- `kill_i` in 1: squash in-flight op (pipeline flush).
- `v_o` out 1: result valid.
- `result_o` out `width_p`: quotient or remainder.
- `rd_o` out `tag_width_p`: tag of the result.
- `yumi_i` in 1: consumer takes the result; legal only when `v_o`=1.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, `v_i & ready_o`:
  - Latch op, tag, `|rs1|`, `|rs2|` (magnitudes for DIV/REM; raw for DIVU/REMU).
  - Latch the sign flags: quotient negative = signed & (rs1[31]^rs2[31]); remainder negative = signed & rs1[31].
  - Clear the remainder register (`width_p`+1 bits) and set the counter to 0.
- Fast paths go directly to DONE with the result registered:
  - Divisor 0: quotient = all ones; remainder = rs1_i unmodified.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
- Otherwise go to CALC. Each CALC cycle performs one restoring step:
  - rem' = {rem, dividend MSB}; shift the dividend left.
  - If rem' ≥ divisor: subtract and shift in quotient bit 1; else shift in 0.
  - Counter increments.
- After the 32nd step (counter = `width_p`-1), go to DONE. Sign fixup (two's-complement negate where flagged) and quotient/remainder select are applied on that transition and stored in `result_o`.
- DONE:
  - `v_o`=1; `result_o` and `rd_o` are held stable until `yumi_i`.
  - `yumi_i` → IDLE. No accept in the same cycle, because `ready_o` is low in DONE.
- `kill_i` (any state other than IDLE) → IDLE next cycle. No `v_o` for the killed op. `kill_i` overrides `yumi_i`.
- `kill_i` and `v_i` together in IDLE: `kill_i` has priority; the request is dropped.

## Timing
- Reset (asynchronous assert, any state): state=IDLE; `v_o`=0, `result_o`=0, `rd_o`=0, counter=0. `ready_o`=1 once `reset_n_i` is high.
- Accept in cycle T: normal path `v_o`=1 at T+33 (CALC T+1..T+32, DONE T+33); fast path `v_o`=1 at T+1.
- First possible accept after `yumi_i` in cycle U: U+1.
- `ready_o` is a function of state only; no combinational path from `v_i`.
- `v_o`, `result_o` and `rd_o` are registered outputs; no combinational path from inputs.
- Counter width: $clog2(`width_p`)+1; never wraps in legal operation.

## Structure
- `bsg_vanilla_pkg` gains the `idiv_op_e` enum (2-bit) and a packed request struct {op, rs1, rs2, rd}.
- The state enum stays local to the module.
- One combinational sub-module is natural: `vanilla_idiv_step`, the restore/subtract step. Inputs are rem, dividend MSB, divisor; outputs are next rem and quotient bit.
- Decode of RV32M funct3 to `idiv_op_e` stays in the decoder, not in this block.

## Test plan
- DIVU 100/7 accepted at T → `v_o`=1 at T+33, `result_o`=14; REMU 100/7 → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIV 7 / 0xFFFFFFFE → 0xFFFFFFFD.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 0xFFFFFFF9/0 → 0xFFFFFFF9 at T+1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM same operands → 0.
- Backpressure: `yumi_i` held low 10 cycles after `v_o` → `result_o`/`rd_o` stable and `ready_o`=0 throughout. `yumi_i` at U → `ready_o`=1 at U+1, back-to-back op accepted at U+1.
- Flush/reset:
  - `kill_i` at T+10 → IDLE at T+11, `ready_o`=1, no `v_o`.
  - `reset_n_i` low at T+5 → `v_o`/`result_o`/`rd_o`=0 immediately. After release, a DIVU 9/3 returns 3.
